// File: rtl/rom_dumper.sv
// rom_dumper
//
// Read-back engine for SDRAM ROM regions written by the ROM loader. A start
// pulse streams `size` bytes of the region at `base_addr` out through the HPS
// ioctl upload interface. It uses the loader's byte-to-word mapping, including
// the optional 64-byte reorder, so the uploaded stream comes out in the byte
// order that was originally downloaded.
//
// Ports:
//   sys_clk     - system clock (only clock)
//   reset       - synchronous, active-high reset
//   start       - one-cycle pulse that begins a dump (ignored while busy)
//   base_addr   - byte base address of the region (bit 0 ignored)
//   size        - number of bytes to dump
//   reorder_64  - selects the loader's 64-byte reorder address mapping
//   busy        - high while a dump is in progress
//   done        - one-cycle pulse when the last byte is taken, or on start with size 0
//   sdr_addr    - SDRAM word address (byte address bits [24:1])
//   sdr_req     - read request level, held until sdr_rdy
//   sdr_rdy     - read complete; sdr_q is valid in the same cycle
//   sdr_q       - SDRAM read data
//   ioctl_rd    - HPS strobe that consumes the current byte
//   ioctl_din   - current byte presented to the HPS
//   ioctl_wait  - high while the current byte is not yet valid
module rom_dumper #(
    parameter int SIZE_W = 25
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [24:0]       base_addr,
    input  logic [SIZE_W-1:0] size,
    input  logic              reorder_64,
    output logic              busy,
    output logic              done,
    output logic [23:0]       sdr_addr,
    output logic              sdr_req,
    input  logic              sdr_rdy,
    input  logic [15:0]       sdr_q,
    input  logic              ioctl_rd,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [23:0]       base_word;
    logic [SIZE_W-1:0] size_lat;
    logic              reorder_lat;
    logic [SIZE_W-1:0] offset;
    logic [SIZE_W-1:0] offset_next;
    logic [15:0]       word_buf;

    logic              accept_start;
    logic              start_empty;
    logic              fetch_hit;
    logic              byte_taken;
    logic              last_byte;

    // Regions are word aligned, so the low byte-address bit carries no meaning.
    logic              unused_base_lsb;
    assign unused_base_lsb = base_addr[0];

    // Word offset that a byte offset lands on. The reorder variant reproduces
    // the loader's shuffle within each 64-word block; the byte lane itself is
    // always selected by off[0].
    function automatic logic [23:0] word_term(input logic [24:0] off, input logic reo);
        logic [23:0] term;
        if (reo) begin
            term = {off[24:7], off[5:2], off[6], off[1]};
        end else begin
            term = off[24:1];
        end
        return term;
    endfunction

    // State register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the handshake-level outputs. sdr_req and
    // ioctl_wait are pure state decodes, so a reset drops both on the very
    // edge that returns the machine to IDLE.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        start_empty  = 1'b0;
        fetch_hit    = 1'b0;
        byte_taken   = 1'b0;
        last_byte    = 1'b0;
        offset_next  = offset + SIZE_W'(1);

        unique case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    if (size == '0) begin
                        start_empty = 1'b1;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (sdr_rdy) begin
                    fetch_hit  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ioctl_rd) begin
                    byte_taken = 1'b1;
                    if (offset == size_lat - SIZE_W'(1)) begin
                        last_byte  = 1'b1;
                        state_next = IDLE;
                    end else if (offset[0]) begin
                        // Both bytes of the buffered word used: next word needs SDRAM.
                        state_next = FETCH;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign sdr_req    = (state == FETCH);
    assign ioctl_wait = (state == FETCH);
    assign ioctl_din  = offset[0] ? word_buf[15:8] : word_buf[7:0];

    // Datapath: latched job parameters, byte offset, word buffer and the SDRAM
    // address. The address is computed on the edge that enters FETCH so it is
    // already stable in the first request cycle, and it is left untouched once
    // the dump ends.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            base_word   <= '0;
            size_lat    <= '0;
            reorder_lat <= 1'b0;
            offset      <= '0;
            word_buf    <= '0;
            sdr_addr    <= '0;
            done        <= 1'b0;
        end else begin
            done <= start_empty | last_byte;

            if (accept_start) begin
                base_word   <= base_addr[24:1];
                size_lat    <= size;
                reorder_lat <= reorder_64;
                offset      <= '0;
                if (!start_empty) begin
                    sdr_addr <= base_addr[24:1];
                end
            end

            if (fetch_hit) begin
                word_buf <= sdr_q;
            end

            if (byte_taken && !last_byte) begin
                offset <= offset_next;
                if (offset[0]) begin
                    sdr_addr <= base_word + word_term(25'(offset_next), reorder_lat);
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_dumper.sv
// tb_rom_dumper
//
// Directed bench for rom_dumper. A small SDRAM responder answers requests
// from a sparse word memory after a programmable delay; the main process
// walks through the dump scenarios and compares against hand-computed values.
module tb_rom_dumper;

    logic        sys_clk;
    logic        reset;
    logic        start;
    logic [24:0] base_addr;
    logic [24:0] size;
    logic        reorder_64;
    logic        busy;
    logic        done;
    logic [23:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_rdy;
    logic [15:0] sdr_q;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    int          assertCount;
    int          failCount;

    logic [15:0] mem [int unsigned];
    int          respDelay;
    logic        respEnable;
    logic        injectRdy;
    int          waitCnt;

    int          reqCount;
    logic [23:0] addrLog [$];
    int          doneCount;

    rom_dumper #(.SIZE_W(25)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .size       (size),
        .reorder_64 (reorder_64),
        .busy       (busy),
        .done       (done),
        .sdr_addr   (sdr_addr),
        .sdr_req    (sdr_req),
        .sdr_rdy    (sdr_rdy),
        .sdr_q      (sdr_q),
        .ioctl_rd   (ioctl_rd),
        .ioctl_din  (ioctl_din),
        .ioctl_wait (ioctl_wait)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] memRead(input logic [23:0] a);
        int unsigned key;
        key = int'(a);
        if (mem.exists(key)) return mem[key];
        return 16'h0000;
    endfunction

    // SDRAM responder: answers a held request after respDelay cycles with a
    // one-cycle sdr_rdy; injectRdy forces a stray sdr_rdy regardless of req.
    always @(negedge sys_clk) begin
        if (injectRdy) begin
            sdr_rdy = 1'b1;
            sdr_q   = 16'hdead;
        end else if (sdr_rdy) begin
            sdr_rdy = 1'b0;
            waitCnt = 0;
        end else if (respEnable && sdr_req) begin
            waitCnt = waitCnt + 1;
            if (waitCnt >= respDelay) begin
                sdr_rdy = 1'b1;
                sdr_q   = memRead(sdr_addr);
                waitCnt = 0;
            end
        end else begin
            waitCnt = 0;
        end
    end

    // Handshake and done monitors.
    always @(posedge sys_clk) begin
        if (sdr_req && sdr_rdy) begin
            reqCount = reqCount + 1;
            addrLog.push_back(sdr_addr);
        end
    end

    always @(negedge sys_clk) begin
        if (done) doneCount = doneCount + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(negedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount = assertCount + 1;
        if (observed !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [24:0] b, input logic [24:0] s, input logic r);
        base_addr  = b;
        size       = s;
        reorder_64 = r;
        start      = 1'b1;
        tick;
        start      = 1'b0;
    endtask

    task automatic readByte(input logic [7:0] expected, input string tag);
        int n;
        n = 0;
        while (ioctl_wait && n < 200) begin
            tick;
            n++;
        end
        if (n >= 200) checkOutput({tag, " timeout"}, 32'd1, 32'd0);
        checkOutput(tag, {24'd0, ioctl_din}, {24'd0, expected});
        ioctl_rd = 1'b1;
        tick;
        ioctl_rd = 1'b0;
    endtask

    task automatic preloadReorder;
        logic [6:0]  ob;
        logic [23:0] wa;
        for (int o = 0; o < 128; o++) begin
            ob = o[6:0];
            wa = {18'd0, ob[5:2], ob[6], ob[1]};
            if (!mem.exists(int'(wa))) mem[int'(wa)] = 16'h0000;
            if (ob[0]) mem[int'(wa)][15:8] = 8'(o);
            else       mem[int'(wa)][7:0]  = 8'(o);
        end
    endtask

    initial begin
        int reqBase;
        int doneBase;
        int logBase;
        int seen;
        int n;
        logic [7:0] ob;

        assertCount = 0;
        failCount   = 0;
        reqCount    = 0;
        doneCount   = 0;
        respDelay   = 1;
        respEnable  = 1'b1;
        injectRdy   = 1'b0;
        waitCnt     = 0;
        sdr_rdy     = 1'b0;
        sdr_q       = 16'h0000;
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        size        = '0;
        reorder_64  = 1'b0;
        ioctl_rd    = 1'b0;

        mem[32'h80000] = 16'h2211;
        mem[32'h80001] = 16'h4433;
        preloadReorder;

        // Reset state.
        repeat (3) tick;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset sdr_req", {31'd0, sdr_req}, 32'd0);
        checkOutput("reset sdr_addr", {8'd0, sdr_addr}, 32'd0);
        checkOutput("reset ioctl_din", {24'd0, ioctl_din}, 32'd0);
        checkOutput("reset ioctl_wait", {31'd0, ioctl_wait}, 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (sdr_req || busy) seen++;
        end
        checkOutput("idle no request", seen, 32'd0);

        // Linear 4-byte dump.
        $display("[TB] linear dump, size 4");
        reqBase = reqCount;
        doneBase = doneCount;
        logBase = addrLog.size();
        applyStimulus(25'h100000, 25'd4, 1'b0);
        checkOutput("start latency sdr_req", {31'd0, sdr_req}, 32'd1);
        checkOutput("start busy", {31'd0, busy}, 32'd1);
        checkOutput("start sdr_addr", {8'd0, sdr_addr}, 32'h080000);
        checkOutput("fetch ioctl_wait", {31'd0, ioctl_wait}, 32'd1);
        readByte(8'h11, "lin byte0");
        readByte(8'h22, "lin byte1");
        readByte(8'h33, "lin byte2");
        readByte(8'h44, "lin byte3");
        checkOutput("lin done pulse", {31'd0, done}, 32'd1);
        checkOutput("lin busy falls", {31'd0, busy}, 32'd0);
        tick;
        checkOutput("lin done cleared", {31'd0, done}, 32'd0);
        checkOutput("lin sdr_addr kept", {8'd0, sdr_addr}, 32'h080001);
        checkOutput("lin request count", reqCount - reqBase, 32'd2);
        checkOutput("lin addr0", {8'd0, addrLog[logBase]}, 32'h080000);
        checkOutput("lin addr1", {8'd0, addrLog[logBase+1]}, 32'h080001);
        checkOutput("lin done count", doneCount - doneBase, 32'd1);

        // Reordered 128-byte dump.
        $display("[TB] reorder dump, size 128");
        reqBase = reqCount;
        logBase = addrLog.size();
        applyStimulus(25'h0, 25'd128, 1'b1);
        for (int o = 0; o < 128; o++) begin
            ob = 8'(o);
            readByte(ob, "reorder byte");
        end
        checkOutput("reorder done", {31'd0, done}, 32'd1);
        checkOutput("reorder request count", reqCount - reqBase, 32'd64);
        checkOutput("reorder addr off2", {8'd0, addrLog[logBase+1]}, 32'h000001);
        checkOutput("reorder addr off4", {8'd0, addrLog[logBase+2]}, 32'h000004);
        checkOutput("reorder addr off64", {8'd0, addrLog[logBase+32]}, 32'h000002);
        tick;

        // Empty dump.
        $display("[TB] size 0 and size 3");
        reqBase = reqCount;
        doneBase = doneCount;
        applyStimulus(25'h100000, 25'd0, 1'b0);
        checkOutput("size0 done", {31'd0, done}, 32'd1);
        checkOutput("size0 busy", {31'd0, busy}, 32'd0);
        checkOutput("size0 sdr_req", {31'd0, sdr_req}, 32'd0);
        tick;
        checkOutput("size0 done cleared", {31'd0, done}, 32'd0);
        checkOutput("size0 busy stays low", {31'd0, busy}, 32'd0);
        checkOutput("size0 no requests", reqCount - reqBase, 32'd0);

        // Odd size: high byte of the last word is fetched but not presented.
        reqBase = reqCount;
        applyStimulus(25'h100000, 25'd3, 1'b0);
        readByte(8'h11, "odd byte0");
        readByte(8'h22, "odd byte1");
        checkOutput("odd not done early", {31'd0, done}, 32'd0);
        readByte(8'h33, "odd byte2");
        checkOutput("odd done", {31'd0, done}, 32'd1);
        checkOutput("odd busy falls", {31'd0, busy}, 32'd0);
        checkOutput("odd request count", reqCount - reqBase, 32'd2);
        tick;

        // Slow SDRAM with a stray ioctl_rd and a second start during FETCH.
        $display("[TB] delayed sdr_rdy");
        respDelay = 7;
        reqBase = reqCount;
        doneBase = doneCount;
        applyStimulus(25'h100000, 25'd2, 1'b0);
        checkOutput("slow wait high", {31'd0, ioctl_wait}, 32'd1);
        ioctl_rd  = 1'b1;
        base_addr = 25'h0;
        size      = 25'd0;
        start     = 1'b1;
        tick;
        ioctl_rd  = 1'b0;
        start     = 1'b0;
        seen = 0;
        n = 0;
        while (!sdr_rdy && n < 20) begin
            if (!ioctl_wait) seen++;
            tick;
            n++;
        end
        checkOutput("slow rdy arrived", {31'd0, sdr_rdy}, 32'd1);
        checkOutput("slow wait held", seen, 32'd0);
        checkOutput("slow wait at rdy", {31'd0, ioctl_wait}, 32'd1);
        tick;
        checkOutput("slow wait after rdy", {31'd0, ioctl_wait}, 32'd0);
        checkOutput("slow data after rdy", {24'd0, ioctl_din}, 32'h11);
        readByte(8'h11, "slow byte0");
        readByte(8'h22, "slow byte1");
        checkOutput("slow done", {31'd0, done}, 32'd1);
        checkOutput("slow request count", reqCount - reqBase, 32'd1);
        checkOutput("slow done count", doneCount - doneBase, 32'd1);
        respDelay = 1;
        tick;

        // Reset while a request is outstanding.
        $display("[TB] reset mid-dump");
        respEnable = 1'b0;
        applyStimulus(25'h100000, 25'd4, 1'b0);
        tick;
        checkOutput("abort req before reset", {31'd0, sdr_req}, 32'd1);
        reset = 1'b1;
        tick;
        checkOutput("abort sdr_req", {31'd0, sdr_req}, 32'd0);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort sdr_addr", {8'd0, sdr_addr}, 32'd0);
        reset = 1'b0;
        injectRdy = 1'b1;
        tick;
        injectRdy = 1'b0;
        tick;
        tick;
        checkOutput("late rdy busy", {31'd0, busy}, 32'd0);
        checkOutput("late rdy sdr_req", {31'd0, sdr_req}, 32'd0);
        checkOutput("late rdy ioctl_wait", {31'd0, ioctl_wait}, 32'd0);
        checkOutput("late rdy ioctl_din", {24'd0, ioctl_din}, 32'd0);
        respEnable = 1'b1;
        logBase = addrLog.size();
        applyStimulus(25'h100000, 25'd2, 1'b0);
        readByte(8'h11, "restart byte0");
        readByte(8'h22, "restart byte1");
        checkOutput("restart addr", {8'd0, addrLog[logBase]}, 32'h080000);
        checkOutput("restart done", {31'd0, done}, 32'd1);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
